// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the supervisor trap controller.
// Holds privilege, FSM state, interrupt cause codes and sie bit positions.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAP     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam logic [4:0] CAUSE_SSI = 5'd1;
    localparam logic [4:0] CAUSE_STI = 5'd5;
    localparam logic [4:0] CAUSE_SEI = 5'd9;

    localparam int SIE_SSIE    = 1;
    localparam int SIE_STIE    = 5;
    localparam int SIE_SEIE    = 9;
    localparam int SSTATUS_SIE = 1;
    localparam int SIP_SSIP    = 1;

    typedef struct packed {
        logic        is_irq;
        logic [4:0]  cause;
        logic [31:0] epc;
        logic [31:0] tval;
    } trap_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// Trap commit and fetch-redirect bundle between trap_ctrl and the core.
// master = trap_ctrl, slave = CSR file / fetch side.
interface trap_ctrl_if;

    logic        trap_set;
    logic        trap_is_irq;
    logic [4:0]  trap_scause;
    logic [31:0] trap_sepc;
    logic [31:0] trap_stval;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    modport master (
        output trap_set, trap_is_irq, trap_scause,
        output trap_sepc, trap_stval, flush,
        output redirect_valid, redirect_pc, busy,
        input  redirect_ready
    );

    modport slave (
        input  trap_set, trap_is_irq, trap_scause,
        input  trap_sepc, trap_stval, flush,
        input  redirect_valid, redirect_pc, busy,
        output redirect_ready
    );

endinterface

// File: rtl/trap_ctrl_time_counter.sv
// Free-running 32-bit time counter advanced once every TICK_DIV clocks.
// The first increment lands on the TICK_DIV-th edge after reset release.
module time_counter #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] time_value
);

    localparam int unsigned PW =
        (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);

    logic [PW-1:0] r_pre;
    logic [31:0]   r_count;
    logic          w_tick;

    assign w_tick = (r_pre == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_count <= '0;
        end else if (w_tick) begin
            r_pre   <= '0;
            r_count <= r_count + 32'd1;
        end else begin
            r_pre   <= r_pre + PRE_ONE;
        end
    end

    assign time_value = r_count;

endmodule

// File: rtl/trap_ctrl.sv
// Supervisor-mode trap controller: arbitrates exceptions and interrupts,
// commits the trap to the CSR file and redirects fetch to stvec.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  priv_e       cur_priv,
    input  logic        exc_valid,
    input  logic [4:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        irq_ok,
    input  logic [31:0] irq_pc,
    input  logic        ext_irq,
    input  logic [31:0] csr_sstatus_q,
    input  logic [31:0] csr_stvec_q,
    input  logic [31:0] csr_sie_q,
    input  logic [31:0] csr_sip_q,
    input  logic [31:0] stimecmp,
    trap_ctrl_if.master trap_if,
    output logic [31:0] time_value,
    output logic [2:0]  irq_pending
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_stip;
    state_e      r_state;
    state_e      w_next;
    trap_t       r_trap;
    trap_t       w_take;
    logic        w_load;
    logic [31:0] r_rpc;
    logic [31:0] w_time;
    logic [2:0]  w_pend;
    logic [2:0]  w_qual;
    logic        w_gie;
    logic        w_irq;
    logic        w_trap;
    logic        w_redir;
    logic        w_unused;

    time_counter #(
        .TICK_DIV (TICK_DIV)
    ) u_time (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_value (w_time)
    );

    assign w_pend = {r_sync2, r_stip, csr_sip_q[SIP_SSIP]};

    // M-mode never takes S-level interrupts; U always does.
    assign w_gie = (cur_priv == PRIV_U) |
                   ((cur_priv == PRIV_S) &
                    csr_sstatus_q[SSTATUS_SIE]);

    assign w_qual = w_pend & {3{w_gie}} &
                    {csr_sie_q[SIE_SEIE],
                     csr_sie_q[SIE_STIE],
                     csr_sie_q[SIE_SSIE]};

    assign w_irq = irq_ok & (|w_qual);

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_take = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (exc_valid) begin
                    w_load       = 1'b1;
                    w_take.cause = exc_cause;
                    w_take.epc   = exc_pc;
                    w_take.tval  = exc_tval;
                    w_next       = ST_TRAP;
                end else if (w_irq) begin
                    w_load        = 1'b1;
                    w_take.is_irq = 1'b1;
                    w_take.epc    = irq_pc;
                    if (w_qual[2]) begin
                        w_take.cause = CAUSE_SEI;
                    end else if (w_qual[0]) begin
                        w_take.cause = CAUSE_SSI;
                    end else begin
                        w_take.cause = CAUSE_STI;
                    end
                    w_next = ST_TRAP;
                end
            end
            ST_TRAP: begin
                w_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (trap_if.redirect_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_trap  <= '0;
            r_rpc   <= '0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_stip  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sync1 <= ext_irq;
            r_sync2 <= r_sync1;
            r_stip  <= (w_time >= stimecmp);
            if (w_load) begin
                r_trap <= w_take;
            end
            if (r_state == ST_TRAP) begin
                r_rpc <= csr_stvec_q;
            end
        end
    end

    assign w_trap  = (r_state == ST_TRAP);
    assign w_redir = (r_state == ST_REDIRECT);

    assign trap_if.trap_set    = w_trap;
    assign trap_if.flush       = w_trap;
    assign trap_if.trap_is_irq = w_trap & r_trap.is_irq;
    assign trap_if.trap_scause = w_trap ? r_trap.cause : '0;
    assign trap_if.trap_sepc   = w_trap ? r_trap.epc : '0;
    assign trap_if.trap_stval  = w_trap ? r_trap.tval : '0;
    assign trap_if.redirect_valid = w_redir;
    assign trap_if.redirect_pc    = w_redir ? r_rpc : '0;
    assign trap_if.busy        = (r_state != ST_IDLE);

    assign time_value  = w_time;
    assign irq_pending = w_pend;

    assign w_unused = ^{csr_sstatus_q[31:2], csr_sstatus_q[0],
                        csr_sie_q[31:10], csr_sie_q[8:6],
                        csr_sie_q[4:2], csr_sie_q[0],
                        csr_sip_q[31:2], csr_sip_q[0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected traps,
// a negedge monitor pops and compares whenever trap_set is seen.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    priv_e       cur_priv;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        irq_ok;
    logic [31:0] irq_pc;
    logic        ext_irq;
    logic [31:0] sstatus;
    logic [31:0] stvec;
    logic [31:0] sie;
    logic [31:0] sip;
    logic [31:0] stimecmp;
    logic [31:0] time_value;
    logic [2:0]  irq_pending;

    trap_ctrl_if u_if();

    trap_ctrl #(
        .TICK_DIV (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cur_priv      (cur_priv),
        .exc_valid     (exc_valid),
        .exc_cause     (exc_cause),
        .exc_pc        (exc_pc),
        .exc_tval      (exc_tval),
        .irq_ok        (irq_ok),
        .irq_pc        (irq_pc),
        .ext_irq       (ext_irq),
        .csr_sstatus_q (sstatus),
        .csr_stvec_q   (stvec),
        .csr_sie_q     (sie),
        .csr_sip_q     (sip),
        .stimecmp      (stimecmp),
        .trap_if       (u_if),
        .time_value    (time_value),
        .irq_pending   (irq_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_irq;
        logic [4:0]  cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic [31:0] rpc;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] exp_rpc = '0;

    always @(posedge clk) if (rst_n) cyc = cyc + 1;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (u_if.trap_set) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_trap: cause %0d at cyc %0d",
                             u_if.trap_scause, cyc);
                end else begin
                    e = q.pop_front();
                    chk("is_irq", 32'(u_if.trap_is_irq), 32'(e.is_irq));
                    chk("scause", 32'(u_if.trap_scause), 32'(e.cause));
                    chk("sepc", u_if.trap_sepc, e.epc);
                    chk("stval", u_if.trap_stval, e.tval);
                    chk("flush", 32'(u_if.flush), 32'd1);
                    chk("trap_cycle", cyc, e.cyc);
                    exp_rpc = e.rpc;
                end
            end
            if (u_if.redirect_valid) begin
                chk("redirect_pc", u_if.redirect_pc, exp_rpc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic wait_idle();
        int k = 0;
        while (u_if.busy && k < 50) begin
            step();
            k++;
        end
        if (u_if.busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy 1 expected 0");
        end
    endtask

    task automatic exc(input logic [4:0] c,
                       input logic [31:0] pc,
                       input logic [31:0] tv);
        q.push_back('{is_irq: 1'b0, cause: c, epc: pc,
                      tval: tv, rpc: stvec, cyc: cyc + 1});
        exc_valid = 1'b1;
        exc_cause = c;
        exc_pc    = pc;
        exc_tval  = tv;
        step();
        exc_valid = 1'b0;
    endtask

    task automatic push_irq(input logic [4:0] c, input int at);
        q.push_back('{is_irq: 1'b1, cause: c, epc: irq_pc,
                      tval: 32'd0, rpc: stvec, cyc: at});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        cur_priv  = PRIV_S;
        exc_valid = 1'b0;
        exc_cause = '0;
        exc_pc    = '0;
        exc_tval  = '0;
        irq_ok    = 1'b1;
        irq_pc    = 32'h200;
        ext_irq   = 1'b0;
        sstatus   = 32'h2;
        stvec     = 32'h8000;
        sie       = 32'h20;
        sip       = 32'h0;
        stimecmp  = 32'd10;
        u_if.redirect_ready = 1'b1;

        repeat (3) step();
        chk("rst_trap_set", 32'(u_if.trap_set), 32'd0);
        chk("rst_busy", 32'(u_if.busy), 32'd0);
        chk("rst_redirect", 32'(u_if.redirect_valid), 32'd0);
        chk("rst_time", time_value, 32'd0);
        chk("rst_pending", 32'(irq_pending), 32'd0);

        // timer interrupt: STIP registers on edge 11, taken on edge 12
        push_irq(CAUSE_STI, 12);
        rst_n = 1'b1;
        to_cyc(5);
        chk("time_at_5", time_value, 32'd5);
        to_cyc(10);
        chk("stip_before", 32'(irq_pending[1]), 32'd0);
        step();
        chk("stip_rise", 32'(irq_pending[1]), 32'd1);
        step();
        stimecmp = 32'hFFFF_FFFF;
        wait_idle();

        // plain exception
        exc(5'd2, 32'h1004, 32'hDEAD);
        wait_idle();

        // SEI beats SSI; SSI follows after return
        cur_priv = PRIV_U;
        sstatus  = 32'h0;
        sie      = 32'h202;
        ext_irq  = 1'b1;
        n = cyc;
        step();
        step();
        sip = 32'h2;
        push_irq(CAUSE_SEI, n + 3);
        push_irq(CAUSE_SSI, n + 6);
        step();
        ext_irq = 1'b0;
        repeat (3) step();
        sip = 32'h0;
        wait_idle();

        // exception wins over simultaneous timer interrupt
        cur_priv = PRIV_S;
        sstatus  = 32'h2;
        sie      = 32'h20;
        stimecmp = 32'h0;
        n = cyc;
        step();
        exc(5'd7, 32'h3000, 32'h55);
        push_irq(CAUSE_STI, n + 5);
        repeat (3) step();
        stimecmp = 32'hFFFF_FFFF;
        wait_idle();

        // redirect stall; exc pulses while busy are dropped
        sie = 32'h0;
        u_if.redirect_ready = 1'b0;
        exc(5'd3, 32'h4000, 32'h77);
        step();
        stvec = 32'h9000;
        for (int i = 0; i < 5; i++) begin
            chk("stall_busy", 32'(u_if.busy), 32'd1);
            chk("stall_valid", 32'(u_if.redirect_valid), 32'd1);
            exc_valid = (i % 2 == 0);
            exc_pc    = 32'h5000;
            step();
        end
        exc_valid = 1'b0;
        u_if.redirect_ready = 1'b1;
        stvec = 32'h8000;
        wait_idle();

        // time wrap with stimecmp at the top of the range
        force dut.u_time.r_count = 32'hFFFF_FFFD;
        release dut.u_time.r_count;
        step();
        step();
        chk("time_top", time_value, 32'hFFFF_FFFF);
        chk("stip_pre_top", 32'(irq_pending[1]), 32'd0);
        step();
        chk("time_wrap", time_value, 32'd0);
        chk("stip_top", 32'(irq_pending[1]), 32'd1);
        step();
        chk("stip_after_wrap", 32'(irq_pending[1]), 32'd0);
        chk("time_after_wrap", time_value, 32'd1);

        // asynchronous reset in REDIRECT
        u_if.redirect_ready = 1'b0;
        exc(5'd4, 32'h6000, 32'h99);
        step();
        chk("pre_rst_redirect", 32'(u_if.redirect_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_trap_set", 32'(u_if.trap_set), 32'd0);
        chk("arst_flush", 32'(u_if.flush), 32'd0);
        chk("arst_redirect", 32'(u_if.redirect_valid), 32'd0);
        chk("arst_rpc", u_if.redirect_pc, 32'd0);
        chk("arst_busy", 32'(u_if.busy), 32'd0);
        chk("arst_time", time_value, 32'd0);
        chk("arst_pending", 32'(irq_pending), 32'd0);
        u_if.redirect_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        exc(5'd8, 32'h7000, 32'h11);
        wait_idle();
        step();

        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
